reg_file_wr_arbiter: RTL and testbench
======================================

# reg_file_wr_arbiter

Write-port controller for `reg_file_rv32i`. It arbitrates the single register-file write port between two writeback requesters:
- A, the ALU writeback path;
- B, the load/memory writeback path.

After reset it sequences a clear of x1..x31. Its registered outputs connect directly to `cu_rdwrite`, `rd_addr` and `rd_in` of the register file.

## Interface
Parameters:
- XLEN, 32, data width of register-file entries
- NREG, 32, number of architectural registers (x0..x(NREG-1)); address width is clog2(NREG)
- CLEAR_ON_RESET, 1, when 1 the block zero-fills x1..x(NREG-1) after reset; when 0 it enters RUN directly

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A handshake accepted this cycle
- a_addr  in  5  A destination register
- a_data  in  XLEN  A write data
- b_valid  in  1  requester B has a write pending
- b_ready  out  1  B handshake accepted this cycle
- b_addr  in  5  B destination register
- b_data  in  XLEN  B write data
- cu_rdwrite  out  1  register-file write enable (registered)
- rd_addr  out  5  register-file write address (registered)
- rd_in  out  XLEN  register-file write data (registered)
- busy  out  1  high while in CLEAR

## Operation
States:
- CLEAR: clear counter clr_cnt runs from 1 to NREG-1.
  - Each cycle drives cu_rdwrite=1, rd_addr=clr_cnt, rd_in=0, then increments clr_cnt.
  - After issuing address NREG-1, moves to RUN.
  - a_ready=b_ready=0 throughout.
- RUN: round-robin arbitration between A and B.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not granted last.
  - last_grant resets to B, so A wins the first conflict.
  - last_grant updates only on a completed handshake.
- Ready signals:
  - a_ready and b_ready are combinational from state, the valid inputs and last_grant.
  - They never depend on addr or data.
  - At most one ready is high per cycle.
- Handshake (valid && ready at a rising edge):
  - The edge registers cu_rdwrite=1, rd_addr=addr and rd_in=data of the granted requester.
  - Exception: addr==0 is accepted but registers cu_rdwrite=0, so the write is dropped.
- No handshake: the edge registers cu_rdwrite=0; rd_addr and rd_in hold their previous values.
- Requester rule: valid may not drop, and addr/data may not change, while valid is high and ready is low.

## Timing
- Reset values (edge where reset=1): cu_rdwrite=0, rd_addr=0, rd_in=0, a_ready=b_ready=0, clr_cnt=1, last_grant=B.
  - State after that edge: CLEAR if CLEAR_ON_RESET, else RUN.
  - busy=1 if CLEAR_ON_RESET, else 0.
- Clear sequence (edge k = k-th rising edge with reset=0):
  - Edges 1..NREG-1 present rd_addr=k with cu_rdwrite=1.
  - The register file commits each value one edge later.
  - State is RUN after edge NREG-1; busy falls at the same edge.
- Write latency:
  - Handshake at edge n gives outputs valid after edge n.
  - The register file commits at edge n+1.
  - The value is readable on rs1/rs2 after edge n+1.
- Throughput: one write per cycle; back-to-back handshakes produce consecutive write cycles.
- Reset mid-CLEAR or mid-RUN: everything is re-initialised at the reset edge. A write issued in that cycle is lost, and the clear restarts from x1.
- Simultaneous valids with the same addr: the grantee writes first and the other writes next cycle. Last write wins in the register file.

## Structure
- Shared package `reg_file_pkg` (localparams/defines) holds:
  - XLEN, NREG, REG_ADDR_W;
  - state encodings ST_CLEAR=1'b0, ST_RUN=1'b1.
  - `reg_file_rv32i` uses the same package.
- Sub-module `rr_arb2`: two-request round-robin grant logic (req[1:0], last_grant, handshake → grant[1:0], next last_grant).
- The top level contains the FSM, clear counter and output registers.

## Test plan
- Reset then clear: preload the register file with non-zero junk (force), pulse reset 1 cycle.
  - busy=1 for 31 edges.
  - cu_rdwrite=1 with rd_addr stepping 1..31 and rd_in=0.
  - Then x1..x31 read 0 and busy=0.
- Single A write in RUN: a_valid=1, a_addr=1, a_data=0x000000aa.
  - a_ready high the same cycle.
  - Next cycle cu_rdwrite=1, rd_addr=1.
  - rs1 with rs1_addr=1 reads 0xaa one edge later.
- Conflict: a_valid=b_valid=1 held for 4 cycles with A→x2 (0xbb, 0xcc) and B→x3 (0xdd, 0xee).
  - Grant order A, B, A, B.
  - Final x2=0xcc, x3=0xee; never both readies high.
- Write to x0: b_addr=0, b_data=0xFFFFFFFF.
  - b_ready=1 (handshake completes).
  - cu_rdwrite stays 0 and x0 reads 0.
- Stall: a_valid held during CLEAR → a_ready=0 until RUN, then accepted once with the data written.
- Reset mid-clear: assert reset at clear edge 10.
  - Outputs return to reset values.
  - Clear restarts at rd_addr=1 and all 31 writes complete.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
//   Definitions shared by the register file and its write-port arbiter:
//   architectural sizes, FSM state encodings and the grant identifiers used by
//   the two-requester round-robin.
//   No ports (package).
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    // Write-port controller state: zero-fill sequence, then normal arbitration.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Identifies which writeback requester was served most recently.
    typedef enum logic {
        GRANT_A = 1'b0,   // ALU writeback path
        GRANT_B = 1'b1    // load/memory writeback path
    } grant_t;

endpackage

// File: rtl/reg_file_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_file_wr_arbiter_if
//   One writeback request channel into the register-file write arbiter.
//   Signals:
//     valid  requester -> arbiter  write pending
//     ready  arbiter -> requester  handshake accepted this cycle
//     addr   requester -> arbiter  destination register
//     data   requester -> arbiter  write data
//   A pending request must hold valid, addr and data stable until ready.
//   Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface reg_file_wr_arbiter_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) ();

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );

endinterface

// File: rtl/reg_file_wr_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-request round-robin grant logic, purely combinational.
//   Ports:
//     req[1:0]         request vector (bit 0 = A, bit 1 = B), already qualified
//     last_grant       requester served at the most recent handshake
//     handshake        a grant is being consumed this cycle
//     grant[1:0]       one-hot (or zero) grant vector
//     last_grant_next  value to load into the last-grant register
// -----------------------------------------------------------------------------
module rr_arb2
    import reg_file_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    input  logic       handshake,
    output logic [1:0] grant,
    output grant_t     last_grant_next
);

    // A requester yields only when the other one is also requesting and it
    // was itself the one served last; otherwise a request is granted. Since
    // exactly one of the two was served last, at most one grant can be high.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_grant
            localparam grant_t SELF = (gi == 0) ? GRANT_A : GRANT_B;
            assign grant[gi] = req[gi] && !(req[1-gi] && (last_grant == SELF));
        end
    endgenerate

    // Priority only rotates when a transfer actually completes, so a stalled
    // cycle never costs a requester its turn.
    always_comb begin
        last_grant_next = last_grant;
        if (handshake) begin
            last_grant_next = grant[1] ? GRANT_B : GRANT_A;
        end
    end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_file_wr_arbiter
//   Write-port controller for reg_file_rv32i. Shares the single register-file
//   write port between the ALU writeback path (A) and the load writeback
//   path (B) with round-robin arbitration, and zero-fills x1..x(NREG-1)
//   after reset when CLEAR_ON_RESET is set.
//   Ports:
//     clock        single clock, rising edge
//     reset        synchronous, active-high
//     a            request channel A (slave side)
//     b            request channel B (slave side)
//     cu_rdwrite   register-file write enable (registered)
//     rd_addr      register-file write address (registered)
//     rd_in        register-file write data (registered)
//     busy         high while the clear sequence runs
// -----------------------------------------------------------------------------
module reg_file_wr_arbiter #(
    parameter int XLEN           = reg_file_pkg::XLEN,
    parameter int NREG           = reg_file_pkg::NREG,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW            = $clog2(NREG)
) (
    input  logic                  clock,
    input  logic                  reset,
    reg_file_wr_arbiter_if.slave  a,
    reg_file_wr_arbiter_if.slave  b,
    output logic                  cu_rdwrite,
    output logic [AW-1:0]         rd_addr,
    output logic [XLEN-1:0]       rd_in,
    output logic                  busy
);

    import reg_file_pkg::*;

    localparam logic [AW-1:0] FIRST_ADDR = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(NREG - 1);

    state_t          state_reg,      state_next;
    logic [AW-1:0]   clr_cnt_reg,    clr_cnt_next;
    grant_t          last_grant_reg, last_grant_next;
    logic            cu_rdwrite_reg, cu_rdwrite_next;
    logic [AW-1:0]   rd_addr_reg,    rd_addr_next;
    logic [XLEN-1:0] rd_in_reg,      rd_in_next;

    logic            run_en;
    logic [1:0]      req;
    logic [1:0]      grant;
    logic            handshake;

    // Requests only count while arbitrating. Reset masks them too, so a
    // request presented in the reset cycle never sees ready and is retried.
    assign run_en = (state_reg == ST_RUN) && !reset;
    assign req    = {b.valid, a.valid} & {2{run_en}};

    rr_arb2 u_rr_arb2 (
        .req             (req),
        .last_grant      (last_grant_reg),
        .handshake       (handshake),
        .grant           (grant),
        .last_grant_next (last_grant_next)
    );

    // Ready is the grant itself: a function of state, valids and last grant
    // only, never of address or data.
    assign a.ready   = grant[0];
    assign b.ready   = grant[1];
    assign handshake = (a.valid && a.ready) || (b.valid && b.ready);

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state_reg;
        clr_cnt_next    = clr_cnt_reg;
        cu_rdwrite_next = 1'b0;
        rd_addr_next    = rd_addr_reg;
        rd_in_next      = rd_in_reg;

        case (state_reg)
            ST_CLEAR: begin
                cu_rdwrite_next = 1'b1;
                rd_addr_next    = clr_cnt_reg;
                rd_in_next      = '0;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                end else begin
                    clr_cnt_next = clr_cnt_reg + AW'(1);
                end
            end

            ST_RUN: begin
                // A write aimed at x0 is still accepted so the requester
                // moves on, but it must never reach the register file.
                if (grant[0]) begin
                    cu_rdwrite_next = (a.addr != '0);
                    rd_addr_next    = a.addr;
                    rd_in_next      = a.data;
                end else if (grant[1]) begin
                    cu_rdwrite_next = (b.addr != '0);
                    rd_addr_next    = b.addr;
                    rd_in_next      = b.data;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_reg    <= FIRST_ADDR;
            last_grant_reg <= GRANT_B;
            cu_rdwrite_reg <= 1'b0;
            rd_addr_reg    <= '0;
            rd_in_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            clr_cnt_reg    <= clr_cnt_next;
            last_grant_reg <= last_grant_next;
            cu_rdwrite_reg <= cu_rdwrite_next;
            rd_addr_reg    <= rd_addr_next;
            rd_in_reg      <= rd_in_next;
        end
    end

    assign cu_rdwrite = cu_rdwrite_reg;
    assign rd_addr    = rd_addr_reg;
    assign rd_in      = rd_in_reg;
    assign busy       = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_file_wr_arbiter
//   Self-checking bench for reg_file_wr_arbiter. A small behavioural register
//   file sits on the DUT outputs; a reference model tracks the expected
//   outputs and register contents from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_reg_file_wr_arbiter;

    import reg_file_pkg::*;

    localparam int AW         = REG_ADDR_W;
    localparam int CLR_ON_RST = 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            preload;
    logic            cu_rdwrite;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_in;
    logic            busy;

    always #5 clock = ~clock;

    reg_file_wr_arbiter_if #(.DATA_W(XLEN), .ADDR_W(AW)) a_if ();
    reg_file_wr_arbiter_if #(.DATA_W(XLEN), .ADDR_W(AW)) b_if ();

    reg_file_wr_arbiter #(
        .XLEN           (XLEN),
        .NREG           (NREG),
        .CLEAR_ON_RESET (CLR_ON_RST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .a          (a_if.slave),
        .b          (b_if.slave),
        .cu_rdwrite (cu_rdwrite),
        .rd_addr    (rd_addr),
        .rd_in      (rd_in),
        .busy       (busy)
    );

    // Stand-in register file driven by the DUT outputs; preload fills junk.
    logic [XLEN-1:0] tb_rf [NREG];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < NREG; i++) tb_rf[i] <= 32'hdead_0000 | XLEN'(i);
        end else if (cu_rdwrite && rd_addr != '0) begin
            tb_rf[rd_addr] <= rd_in;
        end
    end

    function automatic logic [XLEN-1:0] rf_read(input int idx);
        return (idx == 0) ? '0 : tb_rf[idx];
    endfunction

    // Reference model state
    bit              m_run;
    int              m_clr;
    bit              m_last_b;
    logic            e_we;
    logic [AW-1:0]   e_addr;
    logic [XLEN-1:0] e_data;
    logic [XLEN-1:0] exp_rf [NREG];

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: predict and check readies mid-cycle, advance the model at
    // the edge, then check the registered outputs just after it.
    task automatic step(output bit acc_a, output bit acc_b);
        bit ga;
        bit gb;
        ga = 1'b0;
        gb = 1'b0;
        if (!reset && m_run) begin
            if (a_if.valid && b_if.valid) begin
                ga = m_last_b;
                gb = !m_last_b;
            end else begin
                ga = a_if.valid;
                gb = b_if.valid;
            end
        end
        @(negedge clock);
        check("a_ready", a_if.ready, ga);
        check("b_ready", b_if.ready, gb);
        @(posedge clock);
        if (e_we && e_addr != '0) exp_rf[e_addr] = e_data;
        if (reset) begin
            m_run    = (CLR_ON_RST == 0);
            m_clr    = 1;
            m_last_b = 1'b1;
            e_we     = 1'b0;
            e_addr   = '0;
            e_data   = '0;
        end else if (!m_run) begin
            e_we   = 1'b1;
            e_addr = AW'(m_clr);
            e_data = '0;
            if (m_clr == NREG - 1) m_run = 1'b1;
            else m_clr++;
        end else if (ga) begin
            e_we     = (a_if.addr != '0);
            e_addr   = a_if.addr;
            e_data   = a_if.data;
            m_last_b = 1'b0;
        end else if (gb) begin
            e_we     = (b_if.addr != '0);
            e_addr   = b_if.addr;
            e_data   = b_if.data;
            m_last_b = 1'b1;
        end else begin
            e_we = 1'b0;
        end
        #1;
        check("cu_rdwrite", cu_rdwrite, e_we);
        check("rd_addr", rd_addr, e_addr);
        check("rd_in", rd_in, e_data);
        check("busy", busy, !m_run);
        acc_a = ga;
        acc_b = gb;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 1; i < NREG; i++) begin
            check($sformatf("%s_x%0d", tag, i), rf_read(i), exp_rf[i]);
        end
    endtask

    initial begin
        bit acc_a;
        bit acc_b;
        int n;
        logic [3:0] seq;
        logic [XLEN-1:0] a_vals [2];
        logic [XLEN-1:0] b_vals [2];
        int ia;
        int ib;

        n_vec    = 0;
        n_err    = 0;
        m_run    = 1'b0;
        m_clr    = 1;
        m_last_b = 1'b1;
        e_we     = 1'b0;
        e_addr   = '0;
        e_data   = '0;
        for (int i = 0; i < NREG; i++) exp_rf[i] = 32'hdead_0000 | XLEN'(i);
        exp_rf[0] = '0;

        a_if.valid = 1'b0; a_if.addr = '0; a_if.data = '0;
        b_if.valid = 1'b0; b_if.addr = '0; b_if.data = '0;
        reset   = 1'b1;
        preload = 1'b1;

        // Reset edge with junk preload of the register file.
        step(acc_a, acc_b);
        reset   = 1'b0;
        preload = 1'b0;

        // A request held through the whole clear: accepted on the first RUN cycle.
        a_if.valid = 1'b1; a_if.addr = AW'(5); a_if.data = 32'h0000_0055;
        n = 0;
        acc_a = 1'b0;
        while (!acc_a && n < 40) begin
            step(acc_a, acc_b);
            n++;
        end
        check("stall_accept_edge", n, 32);
        a_if.valid = 1'b0;
        step(acc_a, acc_b);
        check("stall_x5", rf_read(5), 32'h0000_0055);
        check_rf("after_clear");

        // Single A write.
        a_if.valid = 1'b1; a_if.addr = AW'(1); a_if.data = 32'h0000_00aa;
        step(acc_a, acc_b);
        check("single_a_acc", acc_a, 1'b1);
        a_if.valid = 1'b0;
        step(acc_a, acc_b);
        check("single_x1", rf_read(1), 32'h0000_00aa);

        // Write to x0 from B: accepted, dropped.
        b_if.valid = 1'b1; b_if.addr = '0; b_if.data = 32'hffff_ffff;
        step(acc_a, acc_b);
        check("x0_b_acc", acc_b, 1'b1);
        b_if.valid = 1'b0;
        step(acc_a, acc_b);
        check_rf("after_x0");

        // Conflict: both valid for four cycles, last grant was B.
        a_vals[0] = 32'h0000_00bb; a_vals[1] = 32'h0000_00cc;
        b_vals[0] = 32'h0000_00dd; b_vals[1] = 32'h0000_00ee;
        ia = 0; ib = 0; seq = '0;
        for (int c = 0; c < 4; c++) begin
            a_if.valid = (ia < 2); a_if.addr = AW'(2); a_if.data = a_vals[(ia < 2) ? ia : 1];
            b_if.valid = (ib < 2); b_if.addr = AW'(3); b_if.data = b_vals[(ib < 2) ? ib : 1];
            step(acc_a, acc_b);
            seq[c] = acc_b;
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        check("conflict_order", seq, 4'b1010);
        a_if.valid = 1'b0; b_if.valid = 1'b0;
        step(acc_a, acc_b);
        check("conflict_x2", rf_read(2), 32'h0000_00cc);
        check("conflict_x3", rf_read(3), 32'h0000_00ee);

        // Same address from both: grantee first, other next; last write wins.
        a_if.valid = 1'b1; a_if.addr = AW'(4); a_if.data = 32'h0000_0011;
        b_if.valid = 1'b1; b_if.addr = AW'(4); b_if.data = 32'h0000_0022;
        step(acc_a, acc_b);
        if (acc_a) a_if.valid = 1'b0;
        if (acc_b) b_if.valid = 1'b0;
        step(acc_a, acc_b);
        a_if.valid = 1'b0; b_if.valid = 1'b0;
        step(acc_a, acc_b);
        check("same_addr_x4", rf_read(4), 32'h0000_0022);

        // Randomised traffic with occasional mid-run resets.
        acc_a = 1'b1; acc_b = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!(a_if.valid && !acc_a)) begin
                a_if.valid = ($urandom_range(0, 3) != 0);
                a_if.addr  = AW'($urandom_range(0, NREG - 1));
                a_if.data  = $urandom;
            end
            if (!(b_if.valid && !acc_b)) begin
                b_if.valid = ($urandom_range(0, 3) != 0);
                b_if.addr  = AW'($urandom_range(0, NREG - 1));
                b_if.data  = $urandom;
            end
            reset = ($urandom_range(0, 149) == 0);
            step(acc_a, acc_b);
        end
        reset = 1'b0;
        a_if.valid = 1'b0; b_if.valid = 1'b0;
        for (int c = 0; c < 40; c++) step(acc_a, acc_b);
        check_rf("random");

        // Reset at clear edge 10, then the full clear again.
        reset = 1'b1;
        step(acc_a, acc_b);
        reset = 1'b0;
        for (int c = 0; c < 9; c++) step(acc_a, acc_b);
        reset = 1'b1;
        step(acc_a, acc_b);
        reset = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            step(acc_a, acc_b);
            n++;
        end
        check("reclear_len", n, 31);
        step(acc_a, acc_b);
        check_rf("reclear");
        check("reclear_x31", rf_read(31), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
